bids22_bidder: RTL and testbench

Hardware bidder agent for one bidder port of the bids22 auction datapath. It queues bid and retract requests from a local requester and drives them onto a single bidder slot (X, Y or Z) as bid/retract pulses, then waits for the auction's ack/err response. It retries on response timeout, pre-checks bid amounts against the reported balance, and tracks wins per round. It is used for self-driving test harnesses and for on-chip bidder clients.

---
 rtl/bids22_bidder.sv | 189 ++++++++++++++++++
 tb/tb_bids22_bidder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bids22_bidder.sv
// Bidder agent: queues bid/retract requests and drives them onto one auction
// bidder slot as registered pulses, waits for ack/err, retries on timeout.
// Latency: push at edge k -> head staged at k+1 -> bid/retract pulse after k+2.
// Backpressure: req_ready drops when the queue is full, in a roundOver cycle and in reset.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   req_valid/req_ready/req_retract/req_amt   local request handshake
//   bid, bidAmt, retract              registered pulses to the auction
//   ack, err, win, roundOver, balance auction responses and status
//   busy, last_err, timeout_flag, local_reject, won, accepted_cnt  status
module bids22_bidder #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16,
  parameter int MAX_RETRY  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_retract,
  input  logic [15:0] req_amt,
  output logic        bid,
  output logic [15:0] bidAmt,
  output logic        retract,
  input  logic        ack,
  input  logic [1:0]  err,
  input  logic        win,
  input  logic        roundOver,
  input  logic [31:0] balance,
  output logic        busy,
  output logic [1:0]  last_err,
  output logic        timeout_flag,
  output logic        local_reject,
  output logic        won,
  output logic [7:0]  accepted_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, BID, WAIT, RETRACT} state_t;
  state_t state, state_nxt;

  // Request queue plus a one-entry staging register (cur) holding the popped head.
  logic [16:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_empty, fifo_full;
  logic          cur_vld, cur_retract;
  logic [15:0]   cur_amt;
  logic          released;

  logic [WW-1:0] wait_cnt;
  logic [RW-1:0] retry_cnt;

  logic push, pop, take_cur, over_bal;
  logic resp_ack, resp_err;
  logic do_reject, do_retry, do_timeout;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign req_ready  = released & ~fifo_full & ~roundOver;
  assign push       = req_valid & req_ready;

  // The staged head is consumed whenever the FSM sits in IDLE; the queue refills
  // the stage in the same edge so back-to-back bids keep a 3-cycle cadence.
  assign take_cur = (state == IDLE) & cur_vld;
  assign pop      = ~fifo_empty & (~cur_vld | take_cur) & ~roundOver;
  assign over_bal = ({16'h0000, cur_amt} > balance);

  // An ack that coincides with a nonzero err is treated as a rejection.
  assign resp_err = (state == WAIT) & (err != 2'b00);
  assign resp_ack = (state == WAIT) & ack & (err == 2'b00);

  assign busy = (state != IDLE) | ~fifo_empty | cur_vld;

  always_comb begin
    state_nxt  = state;
    do_reject  = 1'b0;
    do_retry   = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (cur_vld) begin
          if (cur_retract)   state_nxt = RETRACT;
          else if (over_bal) do_reject = 1'b1;
          else               state_nxt = BID;
        end
      end
      BID:     state_nxt = WAIT;
      WAIT: begin
        if (resp_err || resp_ack) begin
          state_nxt = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          if (retry_cnt < RETRY_MAX) begin
            state_nxt = BID;
            do_retry  = 1'b1;
          end else begin
            state_nxt  = IDLE;
            do_timeout = 1'b1;
          end
        end
      end
      RETRACT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Round end aborts whatever is in flight, including a decision made this cycle.
    if (roundOver) begin
      state_nxt  = IDLE;
      do_reject  = 1'b0;
      do_retry   = 1'b0;
      do_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_retract, req_amt};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      released     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      cur_vld      <= 1'b0;
      cur_retract  <= 1'b0;
      cur_amt      <= '0;
      wait_cnt     <= '0;
      retry_cnt    <= '0;
      bid          <= 1'b0;
      bidAmt       <= '0;
      retract      <= 1'b0;
      last_err     <= '0;
      timeout_flag <= 1'b0;
      local_reject <= 1'b0;
      won          <= 1'b0;
      accepted_cnt <= '0;
    end else begin
      released     <= 1'b1;
      state        <= state_nxt;
      // Pulses are registered: the pulse cycle is the cycle spent in BID/RETRACT.
      bid          <= (state_nxt == BID);
      retract      <= (state_nxt == RETRACT);
      local_reject <= do_reject;
      if (state == IDLE && state_nxt == BID) bidAmt <= cur_amt;

      if (state == IDLE)  retry_cnt <= '0;
      else if (do_retry)  retry_cnt <= retry_cnt + RW'(1);

      if (state == WAIT && state_nxt == WAIT) wait_cnt <= wait_cnt + WW'(1);
      else                                    wait_cnt <= '0;

      if (do_timeout) timeout_flag <= 1'b1;
      if (resp_err)   last_err     <= err;

      if (roundOver) begin
        won          <= win;
        accepted_cnt <= resp_ack ? 8'd1 : 8'd0;
        fifo_cnt     <= '0;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        cur_vld      <= 1'b0;
      end else begin
        if (resp_ack && accepted_cnt != 8'hFF) accepted_cnt <= accepted_cnt + 8'd1;
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
          2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
          default: fifo_cnt <= fifo_cnt;
        endcase
        if (pop) begin
          cur_vld                <= 1'b1;
          {cur_retract, cur_amt} <= mem[rd_ptr];
        end else if (take_cur) begin
          cur_vld <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bids22_bidder.sv
module tb_bids22_bidder;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_retract = 1'b0;
  logic [15:0] req_amt = '0;
  logic        bid;
  logic [15:0] bidAmt;
  logic        retract;
  logic        ack = 1'b0;
  logic [1:0]  err = '0;
  logic        win = 1'b0;
  logic        roundOver = 1'b0;
  logic [31:0] balance = '0;
  logic        busy;
  logic [1:0]  last_err;
  logic        timeout_flag;
  logic        local_reject;
  logic        won;
  logic [7:0]  accepted_cnt;

  bids22_bidder #(.FIFO_DEPTH(4), .TIMEOUT(16), .MAX_RETRY(2)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_retract(req_retract), .req_amt(req_amt), .bid(bid), .bidAmt(bidAmt),
    .retract(retract), .ack(ack), .err(err), .win(win), .roundOver(roundOver),
    .balance(balance), .busy(busy), .last_err(last_err), .timeout_flag(timeout_flag),
    .local_reject(local_reject), .won(won), .accepted_cnt(accepted_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int bid_cnt = 0, ret_cnt = 0, rej_cnt = 0, push_cnt = 0;
  int pulse_cyc[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bid) begin
      bid_cnt++;
      pulse_cyc.push_back(cyc);
    end
    if (retract)              ret_cnt++;
    if (local_reject)         rej_cnt++;
    if (req_valid && req_ready) push_cnt++;
  end

  // resp: 0 none, 1 ack, 2 err, 3 ack with err together
  typedef struct {
    logic        retr;
    logic [15:0] amt;
    logic [31:0] bal;
    int          resp;
    logic [1:0]  errv;
    int          e_bids;
    int          e_rets;
    int          e_rejs;
    logic [7:0]  e_acc;
    logic [1:0]  e_lerr;
    logic [15:0] e_amt;
  } vec_t;

  vec_t vt[8];
  vec_t vd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   b0, r0, j0;
    logic fire;
    b0 = bid_cnt; r0 = ret_cnt; j0 = rej_cnt; fire = 1'b0;
    balance     = v.bal;
    req_retract = v.retr;
    req_amt     = v.amt;
    req_valid   = 1'b1;
    #1 chk($sformatf("vec%0d_ready", idx), 32'(req_ready), 32'd1);
    tick();
    req_valid   = 1'b0;
    req_retract = 1'b0;
    for (int c = 0; c < 24; c++) begin
      tick();
      ack = 1'b0;
      err = 2'b00;
      if (fire) begin
        ack  = (v.resp == 1) || (v.resp == 3);
        err  = (v.resp >= 2) ? v.errv : 2'b00;
        fire = 1'b0;
      end
      if (bid) fire = 1'b1;
    end
    ack = 1'b0;
    err = 2'b00;
    tick();
    chk($sformatf("vec%0d_bids", idx),   32'(bid_cnt - b0), 32'(v.e_bids));
    chk($sformatf("vec%0d_rets", idx),   32'(ret_cnt - r0), 32'(v.e_rets));
    chk($sformatf("vec%0d_rejs", idx),   32'(rej_cnt - j0), 32'(v.e_rejs));
    chk($sformatf("vec%0d_acc", idx),    32'(accepted_cnt), 32'(v.e_acc));
    chk($sformatf("vec%0d_lerr", idx),   32'(last_err),     32'(v.e_lerr));
    chk($sformatf("vec%0d_bidamt", idx), 32'(bidAmt),       32'(v.e_amt));
    chk($sformatf("vec%0d_busy", idx),   32'(busy),         32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bid"},     32'(bid),          32'd0);
    chk({tag, "_bidamt"},  32'(bidAmt),       32'd0);
    chk({tag, "_retract"}, 32'(retract),      32'd0);
    chk({tag, "_ready"},   32'(req_ready),    32'd0);
    chk({tag, "_busy"},    32'(busy),         32'd0);
    chk({tag, "_lerr"},    32'(last_err),     32'd0);
    chk({tag, "_tflag"},   32'(timeout_flag), 32'd0);
    chk({tag, "_lrej"},    32'(local_reject), 32'd0);
    chk({tag, "_won"},     32'(won),          32'd0);
    chk({tag, "_acc"},     32'(accepted_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   b0, q0, p0;
    logic seen;

    //          retr  amt       bal            resp errv   bids rets rejs acc    lerr   bidAmt
    vt[0] = '{1'b0, 16'h0100, 32'h0000_1000, 1, 2'b00, 1, 0, 0, 8'd1, 2'b00, 16'h0100};
    vt[1] = '{1'b0, 16'h2000, 32'h0000_1FFF, 0, 2'b00, 0, 0, 1, 8'd1, 2'b00, 16'h0100};
    vt[2] = '{1'b0, 16'h1FFF, 32'h0000_1FFF, 1, 2'b00, 1, 0, 0, 8'd2, 2'b00, 16'h1FFF};
    vt[3] = '{1'b0, 16'h0042, 32'h0000_1000, 2, 2'b10, 1, 0, 0, 8'd2, 2'b10, 16'h0042};
    vt[4] = '{1'b1, 16'hFFFF, 32'h0000_0000, 0, 2'b00, 0, 1, 0, 8'd2, 2'b10, 16'h0042};
    vt[5] = '{1'b0, 16'hFFFF, 32'h0001_0000, 3, 2'b01, 1, 0, 0, 8'd2, 2'b01, 16'hFFFF};
    vt[6] = '{1'b0, 16'h0000, 32'h0000_0000, 1, 2'b00, 1, 0, 0, 8'd3, 2'b01, 16'h0000};
    vt[7] = '{1'b0, 16'h8000, 32'h0000_7FFF, 0, 2'b00, 0, 0, 1, 8'd3, 2'b01, 16'h0000};
    vd    = '{1'b0, 16'h0123, 32'h0000_1000, 1, 2'b00, 1, 0, 0, 8'd1, 2'b00, 16'h0123};

    // Reset state
    tick();
    tick();
    chk_all_zero("rst");
    reset_n = 1'b1;
    tick();
    chk("rst_release_ready", 32'(req_ready), 32'd1);

    // Single transactions from the table
    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // Latency and timeout with retries
    b0 = bid_cnt;
    q0 = pulse_cyc.size();
    balance   = 32'h0000_1000;
    req_amt   = 16'h0077;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("lat_k1_bid", 32'(bid), 32'd0);
    tick();
    chk("lat_k2_bid", 32'(bid), 32'd1);
    chk("lat_k2_amt", 32'(bidAmt), 32'h0077);
    chk("to_flag_pre", 32'(timeout_flag), 32'd0);
    for (int c = 0; c < 80 && !timeout_flag; c++) tick();
    repeat (20) tick();
    chk("to_flag", 32'(timeout_flag), 32'd1);
    chk("to_pulses", 32'(bid_cnt - b0), 32'd3);
    chk("to_busy", 32'(busy), 32'd0);
    if (pulse_cyc.size() >= q0 + 3) begin
      chk("to_space1", 32'(pulse_cyc[q0+1] - pulse_cyc[q0]),   32'd17);
      chk("to_space2", 32'(pulse_cyc[q0+2] - pulse_cyc[q0+1]), 32'd17);
    end else begin
      chk("to_pulse_log", 32'(pulse_cyc.size() - q0), 32'd3);
    end

    // Round end during the first WAIT with three bids queued behind it
    b0 = bid_cnt;
    balance   = 32'h0000_1000;
    req_valid = 1'b1;
    req_amt   = 16'h0011; tick();
    req_amt   = 16'h0022; tick();
    req_amt   = 16'h0033; tick();
    chk("ro_first_bid", 32'(bid), 32'd1);
    req_amt   = 16'h0044; tick();
    req_valid = 1'b0;
    #1 chk("ro_ready_before", 32'(req_ready), 32'd1);
    roundOver = 1'b1;
    win       = 1'b1;
    #1 chk("ro_ready_during", 32'(req_ready), 32'd0);
    tick();
    roundOver = 1'b0;
    win       = 1'b0;
    #1 chk("ro_ready_after", 32'(req_ready), 32'd1);
    chk("ro_won", 32'(won), 32'd1);
    chk("ro_acc", 32'(accepted_cnt), 32'd0);
    chk("ro_busy", 32'(busy), 32'd0);
    repeat (30) tick();
    chk("ro_pulses", 32'(bid_cnt - b0), 32'd1);
    chk("ro_tflag_kept", 32'(timeout_flag), 32'd1);

    // Full queue backpressure, then ack in the same cycle as roundOver
    b0 = bid_cnt;
    req_amt   = 16'h0055;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      tick();
      if (bid) seen = 1'b1;
    end
    chk("full_bid_seen", 32'(seen), 32'd1);
    tick();
    p0 = push_cnt;
    req_valid = 1'b1;
    repeat (6) tick();
    req_valid = 1'b0;
    chk("full_pushes", 32'(push_cnt - p0), 32'd5);
    #1 chk("full_ready", 32'(req_ready), 32'd0);
    ack       = 1'b1;
    roundOver = 1'b1;
    win       = 1'b0;
    tick();
    ack       = 1'b0;
    roundOver = 1'b0;
    chk("ackro_acc", 32'(accepted_cnt), 32'd1);
    chk("ackro_won", 32'(won), 32'd0);
    chk("ackro_busy", 32'(busy), 32'd0);
    repeat (20) tick();
    chk("ackro_pulses", 32'(bid_cnt - b0), 32'd1);

    // Reset in the middle of WAIT
    req_amt   = 16'h0066;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      tick();
      if (bid) seen = 1'b1;
    end
    chk("mid_bid_seen", 32'(seen), 32'd1);
    repeat (3) tick();
    reset_n = 1'b0;
    #1 chk_all_zero("midrst");
    tick();
    tick();
    reset_n = 1'b1;
    b0 = bid_cnt;
    repeat (30) tick();
    chk("midrst_no_pulse", 32'(bid_cnt - b0), 32'd0);
    run_vec(vd, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
